// File: rtl/alarm_pkg.sv
// Alarm controller shared definitions: state encodings, time field widths and limits.
package alarm_pkg;

  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned STATE_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_e;

endpackage : alarm_pkg

// File: rtl/alarm_wrap_inc.sv
// Modulo-N increment register: counts 0..N-1 on each inc pulse, wrapping to 0.
module alarm_wrap_inc #(
  parameter int unsigned W = 6,
  parameter int unsigned N = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] val_o
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  // Next value: hold, or advance with wrap at N-1
  always_comb begin
    val_d = val_q;
    if (inc_i) begin
      if (val_q == W'(N - 1)) val_d = '0;
      else                    val_d = val_q + W'(1);
    end
  end

  // Value register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign val_o = val_q;

endmodule : alarm_wrap_inc

// File: rtl/alarm_controller.sv
// Alarm sequencer: stores the alarm time, matches it against the running clock
// and drives a 1 s on / 1 s off buzzer until stopped, snoozed or timed out.
// Optional snooze support is compiled in with `define ALARM_SNOOZE_EN.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned CNT_W            = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tick,
  input  logic [SEC_W-1:0]  i_sec,
  input  logic [MIN_W-1:0]  i_min,
  input  logic [HOUR_W-1:0] i_hour,
  input  logic              i_arm_tgl,
  input  logic              i_stop,
  input  logic              i_snooze,
  input  logic              i_alm_min_inc,
  input  logic              i_alm_hour_inc,
  output logic [MIN_W-1:0]  o_alm_min,
  output logic [HOUR_W-1:0] o_alm_hour,
  output logic [1:0]        o_state,
  output logic              o_ring,
  output logic              o_buzz
);

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat_q, beat_d;
  logic             ring_q, ring_d;
  logic             buzz_q, buzz_d;
  logic             match_c;
  logic             snooze_req_c;

  // Stored alarm minute and hour
  alarm_wrap_inc #(.W(MIN_W), .N(MAX_MIN + 1)) u_alm_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (i_alm_min_inc),
    .val_o (o_alm_min)
  );

  alarm_wrap_inc #(.W(HOUR_W), .N(MAX_HOUR + 1)) u_alm_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (i_alm_hour_inc),
    .val_o (o_alm_hour)
  );

`ifdef ALARM_SNOOZE_EN
  assign snooze_req_c = i_snooze;
`else
  // Snooze input and its duration are kept on the interface but have no effect
  logic unused_snooze;
  assign unused_snooze = ^{i_snooze, 32'(SNOOZE_SEC)};
  assign snooze_req_c  = 1'b0;
`endif

  // Alarm hit: exactly at hh:mm:00 on the seconds tick
  assign match_c = i_tick && (i_hour == o_alm_hour) && (i_min == o_alm_min)
                   && (i_sec == '0);

  // Next state, tick counter, beat and registered output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;

    if (i_arm_tgl) begin
      state_d = (state_q == ST_IDLE) ? ST_ARMED : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ARMED: begin
          if (match_c) begin
            state_d = ST_RINGING;
            cnt_d   = '0;
          end
        end
        ST_RINGING: begin
          if (i_stop) begin
            state_d = ST_ARMED;
          end else if (snooze_req_c) begin
            state_d = ST_SNOOZE;
            cnt_d   = CNT_W'(SNOOZE_SEC);
          end else if (i_tick) begin
            if (cnt_q == CNT_W'(RING_TIMEOUT_SEC - 1)) state_d = ST_ARMED;
            else                                       cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
          if (i_stop) begin
            state_d = ST_ARMED;
          end else if (i_tick) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = ST_RINGING;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
`else
          state_d = ST_IDLE;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Counter only carries meaning while ringing or snoozing
    if ((state_d == ST_IDLE) || (state_d == ST_ARMED)) cnt_d = '0;

    // Beat starts high on ring entry, toggles per tick, clears on exit
    if (state_d != ST_RINGING)       beat_d = 1'b0;
    else if (state_q != ST_RINGING)  beat_d = 1'b1;
    else if (i_tick)                 beat_d = ~beat_q;

    ring_d = (state_d == ST_RINGING);
    buzz_d = ring_d & beat_d;
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      beat_q  <= 1'b0;
      ring_q  <= 1'b0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      ring_q  <= ring_d;
      buzz_q  <= buzz_d;
    end
  end

  assign o_state = 2'(state_q);
  assign o_ring  = ring_q;
  assign o_buzz  = buzz_q;

endmodule : alarm_controller

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller (short timeouts: ring 4, snooze 3).
module tb_alarm_controller;

  logic       clk;
  logic       rst_n;
  logic       i_tick;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hour;
  logic       i_arm_tgl;
  logic       i_stop;
  logic       i_snooze;
  logic       i_alm_min_inc;
  logic       i_alm_hour_inc;
  logic [5:0] o_alm_min;
  logic [4:0] o_alm_hour;
  logic [1:0] o_state;
  logic       o_ring;
  logic       o_buzz;

  int n_checks = 0;
  int n_errors = 0;

  alarm_controller #(
    .RING_TIMEOUT_SEC (4),
    .SNOOZE_SEC       (3),
    .CNT_W            (9)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tick         (i_tick),
    .i_sec          (i_sec),
    .i_min          (i_min),
    .i_hour         (i_hour),
    .i_arm_tgl      (i_arm_tgl),
    .i_stop         (i_stop),
    .i_snooze       (i_snooze),
    .i_alm_min_inc  (i_alm_min_inc),
    .i_alm_hour_inc (i_alm_hour_inc),
    .o_alm_min      (o_alm_min),
    .o_alm_hour     (o_alm_hour),
    .o_state        (o_state),
    .o_ring         (o_ring),
    .o_buzz         (o_buzz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: pulses set beforehand are sampled, then cleared; outputs settle by #1
  task automatic cyc();
    @(posedge clk);
    #1;
    i_tick         = 1'b0;
    i_arm_tgl      = 1'b0;
    i_stop         = 1'b0;
    i_snooze       = 1'b0;
    i_alm_min_inc  = 1'b0;
    i_alm_hour_inc = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    i_hour = 5'(h);
    i_min  = 6'(m);
    i_sec  = 6'(s);
  endtask

  task automatic tick();
    i_tick = 1'b1;
    cyc();
  endtask

  task automatic chk_out(input string tag, input int st, input int ring, input int buzz);
    chk({tag, ".state"}, 32'(o_state), 32'(st));
    chk({tag, ".ring"},  32'(o_ring),  32'(ring));
    chk({tag, ".buzz"},  32'(o_buzz),  32'(buzz));
  endtask

  initial begin
    rst_n          = 1'b0;
    i_tick         = 1'b0;
    i_arm_tgl      = 1'b0;
    i_stop         = 1'b0;
    i_snooze       = 1'b0;
    i_alm_min_inc  = 1'b0;
    i_alm_hour_inc = 1'b0;
    set_time(0, 0, 1);

    // Reset values
    #3;
    chk_out("reset", 0, 0, 0);
    chk("reset.alm_min",  32'(o_alm_min),  0);
    chk("reset.alm_hour", 32'(o_alm_hour), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Program alarm to 07:30; editing leaves IDLE alone
    for (int i = 0; i < 30; i++) begin i_alm_min_inc = 1'b1; cyc(); end
    for (int i = 0; i < 7; i++)  begin i_alm_hour_inc = 1'b1; cyc(); end
    chk("set.alm_min",  32'(o_alm_min),  30);
    chk("set.alm_hour", 32'(o_alm_hour), 7);
    chk("set.state",    32'(o_state),    0);

    // Arm; stop/snooze ignored in ARMED
    i_arm_tgl = 1'b1; cyc();
    chk("arm.state", 32'(o_state), 1);
    i_stop = 1'b1; i_snooze = 1'b1; cyc();
    chk("armed_ignore.state", 32'(o_state), 1);

    // Near misses: wrong second, match without tick
    set_time(7, 29, 59); tick();
    chk_out("miss_2959", 1, 0, 0);
    set_time(7, 30, 5); tick();
    chk_out("miss_sec5", 1, 0, 0);
    set_time(7, 30, 0); cyc();
    chk_out("miss_notick", 1, 0, 0);

    // Match -> ringing one cycle after the tick
    tick();
    chk_out("match", 2, 1, 1);
    set_time(7, 30, 1);
    cyc();
    chk_out("ring_idle", 2, 1, 1);

    // Timeout after 4 ticks, buzz 1,0,1,0 across the intervals
    tick(); chk_out("to_t1", 2, 1, 0);
    cyc();  chk_out("to_gap", 2, 1, 0);
    tick(); chk_out("to_t2", 2, 1, 1);
    tick(); chk_out("to_t3", 2, 1, 0);
    tick(); chk_out("to_t4", 1, 0, 0);

    // Ring again, then snooze
    set_time(7, 30, 0); tick();
    chk_out("rering", 2, 1, 1);
    set_time(7, 30, 2);
    i_snooze = 1'b1; cyc();
`ifdef ALARM_SNOOZE_EN
    chk_out("snooze", 3, 0, 0);
    tick(); chk_out("sn_t1", 3, 0, 0);
    tick(); chk_out("sn_t2", 3, 0, 0);
    tick(); chk_out("sn_t3", 2, 1, 1);
`else
    chk_out("snooze_off", 2, 1, 1);
    tick(); chk_out("sn_t1", 2, 1, 0);
    tick(); chk_out("sn_t2", 2, 1, 1);
    tick(); chk_out("sn_t3", 2, 1, 0);
`endif

    // Toggle and stop together while ringing: toggle wins -> IDLE
    i_arm_tgl = 1'b1; i_stop = 1'b1; cyc();
    chk_out("tgl_stop", 0, 0, 0);
    set_time(7, 30, 0); tick();
    chk_out("idle_match", 0, 0, 0);
    set_time(7, 30, 3);

    // Minute wrap without hour carry, hour wrap
    for (int i = 0; i < 29; i++) begin i_alm_min_inc = 1'b1; cyc(); end
    chk("min59", 32'(o_alm_min), 59);
    i_alm_min_inc = 1'b1; cyc();
    chk("min_wrap.min",  32'(o_alm_min),  0);
    chk("min_wrap.hour", 32'(o_alm_hour), 7);
    for (int i = 0; i < 16; i++) begin i_alm_hour_inc = 1'b1; cyc(); end
    chk("hour23", 32'(o_alm_hour), 23);
    i_alm_hour_inc = 1'b1; cyc();
    chk("hour_wrap.hour", 32'(o_alm_hour), 0);
    chk("hour_wrap.min",  32'(o_alm_min),  0);

    // 23:59 with both pulses together -> 00:00
    for (int i = 0; i < 23; i++) begin i_alm_hour_inc = 1'b1; cyc(); end
    for (int i = 0; i < 59; i++) begin i_alm_min_inc = 1'b1; cyc(); end
    chk("t2359.hour", 32'(o_alm_hour), 23);
    chk("t2359.min",  32'(o_alm_min),  59);
    i_alm_min_inc = 1'b1; i_alm_hour_inc = 1'b1; cyc();
    chk("both_wrap.hour", 32'(o_alm_hour), 0);
    chk("both_wrap.min",  32'(o_alm_min),  0);
    chk("both_wrap.state", 32'(o_state),   0);

    // Alarm 00:05, arm, ring, then asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) begin i_alm_min_inc = 1'b1; cyc(); end
    i_arm_tgl = 1'b1; cyc();
    set_time(0, 5, 0); tick();
    chk_out("ring2", 2, 1, 1);
    chk("ring2.alm_min", 32'(o_alm_min), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0);
    chk("async_rst.alm_min",  32'(o_alm_min),  0);
    chk("async_rst.alm_hour", 32'(o_alm_hour), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_alarm_controller

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Alarm sequencer for the digital clock. Holds a user-set alarm time (hour:min) and compares it against the running clock time.
- On a match, drives the buzzer until it is stopped, snoozed or times out.
- Sits beside the clock controller/counters. It consumes their time values and a 1 Hz tick, plus debounced single-cycle button pulses.

Parameters:
- RING_TIMEOUT_SEC, 60, ticks of ringing before auto-return to ARMED
- SNOOZE_SEC, 300, ticks spent in SNOOZE before re-ringing
- CNT_W, 9, width of internal tick counter (must hold max(RING_TIMEOUT_SEC, SNOOZE_SEC))

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  reset; asynchronous, active-low
- i_tick  input  1  1 Hz strobe, one clk cycle wide, clk domain
- i_sec  input  6  current seconds, binary 0..59
- i_min  input  6  current minutes, binary 0..59
- i_hour  input  5  current hours, binary 0..23
- i_arm_tgl  input  1  1-cycle pulse: toggle armed/disarmed
- i_stop  input  1  1-cycle pulse: stop ringing
- i_snooze  input  1  1-cycle pulse: snooze
- i_alm_min_inc  input  1  1-cycle pulse: alarm minute +1
- i_alm_hour_inc  input  1  1-cycle pulse: alarm hour +1
- o_alm_min  output  6  stored alarm minute
- o_alm_hour  output  5  stored alarm hour
- o_state  output  2  FSM state code
- o_ring  output  1  high in RINGING
- o_buzz  output  1  gated buzzer drive

Behaviour:
- One clock, clk. Asynchronous active-low reset rst_n. All state is registered on posedge clk.
- Reset values:
  - state = IDLE, o_state = 2'd0
  - o_alm_min = 0, o_alm_hour = 0 (alarm at 00:00)
  - counter = 0, beat = 0
  - o_ring = 0, o_buzz = 0
- States: IDLE = 0, ARMED = 1, RINGING = 2, SNOOZE = 3.
- Match condition: i_tick = 1 AND i_hour == o_alm_hour AND i_min == o_alm_min AND i_sec == 0, sampled in the tick cycle.
- Per-state transitions, in priority order (highest first):
  - any state, i_arm_tgl: IDLE -> ARMED; ARMED/RINGING/SNOOZE -> IDLE. Overrides every other event in the same cycle.
  - RINGING, i_stop -> ARMED.
  - RINGING, i_snooze -> SNOOZE; counter loaded with SNOOZE_SEC.
  - RINGING, i_tick: counter += 1. When counter reaches RING_TIMEOUT_SEC-1 on a tick -> ARMED.
  - SNOOZE, i_stop -> ARMED. Snooze is cancelled.
  - SNOOZE, i_tick: counter -= 1. When the tick arrives with counter == 1 -> RINGING; counter cleared.
  - ARMED, match -> RINGING next cycle; counter cleared; beat = 1.
  - i_stop or i_snooze in IDLE/ARMED: ignored.
- A match while in RINGING or SNOOZE is ignored; the alarm does not restart.
- o_ring = (state == RINGING), registered with the state, so it asserts 1 cycle after the match tick.
- beat:
  - set to 1 on RINGING entry
  - toggles on each i_tick while RINGING
  - cleared on leaving RINGING
- o_buzz = o_ring & beat, giving 1 s on / 1 s off.
- Alarm set:
  - i_alm_min_inc: 59 -> 0, no carry into hour.
  - i_alm_hour_inc: 23 -> 0.
  - Both accepted in every state and may occur in the same cycle.
  - Editing does not change state. The new value takes part in the match from the next cycle.
- Counter arithmetic is CNT_W-bit unsigned and never wraps, because the transitions above bound it.
- Reset asserted mid-ring or mid-snooze: outputs drop immediately (asynchronous), and the stored alarm time returns to 00:00.

Optional Feature:
- Macro ALARM_SNOOZE_EN.
- Defined: SNOOZE state and i_snooze behave as above.
- Undefined:
  - i_snooze is ignored and SNOOZE is unreachable.
  - SNOOZE_SEC is unused.
  - The port list is unchanged (the input stays, unconnected internally).

Decomposition:
- Package alarm_pkg holds:
  - state encodings ST_IDLE, ST_ARMED, ST_RINGING, ST_SNOOZE
  - widths SEC_W = 6, MIN_W = 6, HOUR_W = 5
  - limits MAX_MIN = 59, MAX_HOUR = 23
- Sub-module alarm_wrap_inc: modulo-N increment register with reset. Instantiated twice, for alarm minute (N = 60) and alarm hour (N = 24).

Test Plan:
- Set alarm to 07:30 (30 min pulses, 7 hour pulses), arm, drive time to 07:30:00 with tick -> o_ring = 1 next cycle, o_buzz = 1, o_state = 2.
- Ringing with RING_TIMEOUT_SEC = 4 -> after 4 ticks o_state = 1 and o_ring = 0; o_buzz pattern over ticks is 1, 0, 1, 0.
- Ringing, i_snooze, SNOOZE_SEC = 3 -> o_state = 3 and o_buzz = 0; on the 3rd tick o_state = 2 and o_buzz = 1. With ALARM_SNOOZE_EN undefined, o_state stays 2.
- Ringing, i_arm_tgl and i_stop in the same cycle -> o_state = 0 (IDLE; toggle wins). A later match causes no ring.
- Alarm min at 59 plus an inc pulse -> 0, hour unchanged; hour at 23 plus an inc pulse -> 0. Both pulses in one cycle from 23:59 -> 00:00.
- Drop rst_n low while RINGING -> o_ring = 0, o_buzz = 0, o_state = 0 and alarm = 00:00 in the same cycle, without waiting for clk.
